// File: rtl/frame_write_scheduler_pkg.sv
// Shared constants for the frame write path: pixel geometry, owner codes,
// scheduler state codes and the saturating write-count helper.
package frame_write_scheduler_pkg;

    localparam int BITS_PER_PIXEL   = 24;
    localparam int PIXELS_PER_FRAME = 64;
    localparam int ADDR_W           = $clog2(PIXELS_PER_FRAME);

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_A    = 2'b01;
    localparam logic [1:0] OWNER_B    = 2'b10;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_OWN    = 3'd1;
    localparam logic [2:0] ST_COMMIT = 3'd2;
    localparam logic [2:0] ST_SEND   = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;

    localparam logic [6:0] COUNT_MAX = 7'd127;

    function automatic logic [6:0] sat_inc7(input logic [6:0] v);
        sat_inc7 = (v == COUNT_MAX) ? v : v + 7'd1;
    endfunction

endpackage

// File: rtl/frame_write_scheduler_rr_arbiter2.sv
// Two-way round-robin picker: a priority register that favours A out of reset
// and is reloaded from outside through an update strobe.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_upd,
    input  logic i_upd_prio_b,
    output logic o_any,
    output logic o_pick_b,
    output logic o_prio_b
);
    import frame_write_scheduler_pkg::*;

    logic r_prio_b;

    // Priority register, reloaded on the update strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prio_b <= 1'b0;
        end else if (i_upd) begin
            r_prio_b <= i_upd_prio_b;
        end
    end

    // Pick: a lone requester wins, a tie goes to the favoured side
    always_comb begin
        o_any    = i_req_a | i_req_b;
        o_prio_b = r_prio_b;
        if (i_req_a && i_req_b) begin
            o_pick_b = r_prio_b;
        end else begin
            o_pick_b = i_req_b;
        end
    end

endmodule

// File: rtl/frame_write_scheduler.sv
// Grants frame ownership to one of two pixel writers, forwards its writes to the
// column mux and commits the frame on the mux frame boundary.
module frame_write_scheduler #(
    parameter int BITS_PER_PIXEL = frame_write_scheduler_pkg::BITS_PER_PIXEL,
    parameter int TIMEOUT        = 1024,
    parameter int SETTLE_CYCLES  = 2
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         i_a_req,
    input  logic [frame_write_scheduler_pkg::ADDR_W-1:0] i_a_addr,
    input  logic [BITS_PER_PIXEL-1:0]                    i_a_value,
    input  logic                                         i_a_last,
    output logic                                         o_a_gnt,
    input  logic                                         i_b_req,
    input  logic [frame_write_scheduler_pkg::ADDR_W-1:0] i_b_addr,
    input  logic [BITS_PER_PIXEL-1:0]                    i_b_value,
    input  logic                                         i_b_last,
    output logic                                         o_b_gnt,
    input  logic                                         i_frame_done,
    output logic                                         o_write_en,
    output logic [frame_write_scheduler_pkg::ADDR_W-1:0] o_pixel_addr,
    output logic [BITS_PER_PIXEL-1:0]                    o_pixel_value,
    output logic                                         o_send_frame,
    output logic [1:0]                                   o_owner,
    output logic [6:0]                                   o_writes_in_frame,
    output logic                                         o_abort
);
    import frame_write_scheduler_pkg::*;

    localparam int              TW          = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]   TIMER_LAST  = TW'(TIMEOUT - 1);
    localparam int              SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]   SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    logic [2:0]                r_state;
    logic [1:0]                r_owner;
    logic                      r_wr_en;
    logic [ADDR_W-1:0]         r_addr;
    logic [BITS_PER_PIXEL-1:0] r_value;
    logic                      r_send;
    logic                      r_abort;
    logic [6:0]                r_count;
    logic [TW-1:0]             r_timer;
    logic [SW-1:0]             r_settle;

    logic                      w_accept;
    logic                      w_timeout;
    logic [ADDR_W-1:0]         w_addr;
    logic [BITS_PER_PIXEL-1:0] w_value;
    logic                      w_last;
    logic                      w_any;
    logic                      w_pick_b;
    logic                      w_prio_b;
    logic                      w_rr_upd;
    logic                      w_rr_prio_b;

    // Grants exist only while owning, and only toward the owner
    assign o_a_gnt   = i_a_req && (r_state == ST_OWN) && (r_owner == OWNER_A);
    assign o_b_gnt   = i_b_req && (r_state == ST_OWN) && (r_owner == OWNER_B);
    assign w_accept  = o_a_gnt | o_b_gnt;
    assign w_timeout = (r_state == ST_OWN) && !w_accept && (r_timer == TIMER_LAST);

    // Route the owner's write fields toward the output registers
    always_comb begin
        if (r_owner == OWNER_B) begin
            w_addr  = i_b_addr;
            w_value = i_b_value;
            w_last  = i_b_last;
        end else begin
            w_addr  = i_a_addr;
            w_value = i_a_value;
            w_last  = i_a_last;
        end
    end

    // A committed frame hands priority to the other side; an abort just flips it
    always_comb begin
        if (r_state == ST_SEND) begin
            w_rr_upd    = 1'b1;
            w_rr_prio_b = (r_owner == OWNER_A);
        end else if (w_timeout) begin
            w_rr_upd    = 1'b1;
            w_rr_prio_b = ~w_prio_b;
        end else begin
            w_rr_upd    = 1'b0;
            w_rr_prio_b = w_prio_b;
        end
    end

    rr_arbiter2 u_rr (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_a      (i_a_req),
        .i_req_b      (i_b_req),
        .i_upd        (w_rr_upd),
        .i_upd_prio_b (w_rr_prio_b),
        .o_any        (w_any),
        .o_pick_b     (w_pick_b),
        .o_prio_b     (w_prio_b)
    );

    // Frame ownership state machine with registered mux-side outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_owner  <= OWNER_NONE;
            r_wr_en  <= 1'b0;
            r_addr   <= {ADDR_W{1'b0}};
            r_value  <= {BITS_PER_PIXEL{1'b0}};
            r_send   <= 1'b0;
            r_abort  <= 1'b0;
            r_count  <= 7'd0;
            r_timer  <= {TW{1'b0}};
            r_settle <= {SW{1'b0}};
        end else begin
            r_wr_en <= 1'b0;
            r_send  <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_pick_b ? OWNER_B : OWNER_A;
                        r_timer <= {TW{1'b0}};
                        r_state <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (w_accept) begin
                        r_wr_en <= 1'b1;
                        r_addr  <= w_addr;
                        r_value <= w_value;
                        r_count <= sat_inc7(r_count);
                        r_timer <= {TW{1'b0}};
                        if (w_last) begin
                            r_state <= ST_COMMIT;
                        end
                    end else if (w_timeout) begin
                        // Pixels already written stay in the inactive grid; no commit
                        r_abort <= 1'b1;
                        r_owner <= OWNER_NONE;
                        r_count <= 7'd0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_COMMIT: begin
                    if (i_frame_done) begin
                        r_send  <= 1'b1;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_settle <= SETTLE_LOAD;
                    r_state  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_settle == {SW{1'b0}}) begin
                        r_owner <= OWNER_NONE;
                        r_count <= 7'd0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_settle <= r_settle - SW'(1);
                    end
                end
                default: begin
                    r_owner <= OWNER_NONE;
                    r_count <= 7'd0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_write_en        = r_wr_en;
    assign o_pixel_addr      = r_addr;
    assign o_pixel_value     = r_value;
    assign o_send_frame      = r_send;
    assign o_owner           = r_owner;
    assign o_writes_in_frame = r_count;
    assign o_abort           = r_abort;

endmodule

// File: tb/tb_frame_write_scheduler.sv
// Directed and randomized checks of frame_write_scheduler against a cycle-level
// model of the frame lifecycle kept in this bench.
module tb_frame_write_scheduler;

    localparam int BPP    = 24;
    localparam int TMO    = 1024;
    localparam int SETTLE = 2;

    localparam int P_FREE = 0, P_WRITING = 1, P_WAIT = 2, P_SENDING = 3, P_QUIET = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           a_req = 1'b0, b_req = 1'b0, a_last = 1'b0, b_last = 1'b0;
    logic [5:0]     a_addr = 6'd0, b_addr = 6'd0;
    logic [BPP-1:0] a_value = 24'd0, b_value = 24'd0;
    logic           frame_done = 1'b0;
    logic           a_gnt, b_gnt, write_en, send_frame, abort_p;
    logic [5:0]     pixel_addr;
    logic [BPP-1:0] pixel_value;
    logic [1:0]     owner;
    logic [6:0]     wif;

    always #5 clk = ~clk;

    frame_write_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .i_a_req(a_req), .i_a_addr(a_addr), .i_a_value(a_value), .i_a_last(a_last), .o_a_gnt(a_gnt),
        .i_b_req(b_req), .i_b_addr(b_addr), .i_b_value(b_value), .i_b_last(b_last), .o_b_gnt(b_gnt),
        .i_frame_done(frame_done), .o_write_en(write_en), .o_pixel_addr(pixel_addr),
        .o_pixel_value(pixel_value), .o_send_frame(send_frame), .o_owner(owner),
        .o_writes_in_frame(wif), .o_abort(abort_p)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: who owns the frame, where it is in its life, what the mux sees
    int             m_phase = P_FREE, m_owner = 0, m_count = 0, m_idle = 0, m_quiet = 0;
    bit             m_prio_b = 1'b0, m_acc = 1'b0;
    bit             e_wr = 1'b0, e_send = 1'b0, e_abort = 1'b0;
    logic [5:0]     e_addr = 6'd0;
    logic [BPP-1:0] e_value = 24'd0;

    int c_wr, c_send, c_abort, c_max_cnt, c_wr_blocked, c_bgnt_under_a, last_nz;
    int seq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        n_cmp++;
        n_bad++;
        $error("FAIL %s observed=bound_expired expected=event", tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_owner"}, 32'(owner), 32'd0);
        check({tag, "_wen"},   32'(write_en), 32'd0);
        check({tag, "_addr"},  32'(pixel_addr), 32'd0);
        check({tag, "_value"}, 32'(pixel_value), 32'd0);
        check({tag, "_send"},  32'(send_frame), 32'd0);
        check({tag, "_wif"},   32'(wif), 32'd0);
        check({tag, "_abort"}, 32'(abort_p), 32'd0);
        check({tag, "_gnts"},  32'({a_gnt, b_gnt}), 32'd0);
    endtask

    task automatic clear_counters();
        c_wr = 0; c_send = 0; c_abort = 0; c_max_cnt = 0;
        c_wr_blocked = 0; c_bgnt_under_a = 0; last_nz = 0;
        seq.delete();
    endtask

    // advance the model by one clock using the inputs currently applied
    task automatic model_step();
        e_wr = 1'b0; e_send = 1'b0; e_abort = 1'b0; m_acc = 1'b0;
        if (!rst_n) begin
            m_phase = P_FREE; m_owner = 0; m_count = 0; m_idle = 0; m_quiet = 0;
            m_prio_b = 1'b0; e_addr = 6'd0; e_value = 24'd0;
        end else begin
            case (m_phase)
                P_FREE: if (a_req || b_req) begin
                    if (a_req && b_req) m_owner = m_prio_b ? 2 : 1;
                    else                m_owner = a_req ? 1 : 2;
                    m_phase = P_WRITING;
                    m_idle = 0;
                end
                P_WRITING: begin
                    m_acc = (m_owner == 1) ? a_req : b_req;
                    if (m_acc) begin
                        e_wr = 1'b1;
                        e_addr  = (m_owner == 1) ? a_addr : b_addr;
                        e_value = (m_owner == 1) ? a_value : b_value;
                        if (m_count < 127) m_count++;
                        m_idle = 0;
                        if ((m_owner == 1) ? a_last : b_last) m_phase = P_WAIT;
                    end else begin
                        m_idle++;
                        if (m_idle == TMO) begin
                            e_abort = 1'b1; m_owner = 0; m_count = 0;
                            m_prio_b = !m_prio_b; m_phase = P_FREE;
                        end
                    end
                end
                P_WAIT: if (frame_done) begin
                    e_send = 1'b1;
                    m_phase = P_SENDING;
                end
                P_SENDING: begin
                    m_prio_b = (m_owner == 1);
                    m_quiet = SETTLE;
                    m_phase = P_QUIET;
                end
                default: begin
                    m_quiet--;
                    if (m_quiet == 0) begin
                        m_owner = 0; m_count = 0; m_phase = P_FREE;
                    end
                end
            endcase
        end
    endtask

    // one clock: compare on the falling edge, step the model, return just after the rising edge
    task automatic cycle();
        bit exp_a, exp_b;
        @(negedge clk);
        exp_a = (m_phase == P_WRITING) && (m_owner == 1) && a_req;
        exp_b = (m_phase == P_WRITING) && (m_owner == 2) && b_req;
        check("a_gnt", 32'(a_gnt), 32'(exp_a));
        check("b_gnt", 32'(b_gnt), 32'(exp_b));
        check("write_en", 32'(write_en), 32'(e_wr));
        if (e_wr) begin
            check("pixel_addr", 32'(pixel_addr), 32'(e_addr));
            check("pixel_value", 32'(pixel_value), 32'(e_value));
        end
        check("send_frame", 32'(send_frame), 32'(e_send));
        check("owner", 32'(owner), 32'(m_owner));
        check("writes_in_frame", 32'(wif), 32'(m_count));
        check("abort", 32'(abort_p), 32'(e_abort));
        c_wr    += int'(write_en);
        c_send  += int'(send_frame);
        c_abort += int'(abort_p);
        if (int'(wif) > c_max_cnt) c_max_cnt = int'(wif);
        if (write_en && (m_phase == P_SENDING || m_phase == P_QUIET)) c_wr_blocked++;
        if (b_gnt && owner == 2'b01) c_bgnt_under_a++;
        if (owner != 2'b00 && int'(owner) != last_nz) begin
            last_nz = int'(owner);
            seq.push_back(last_nz);
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int ph, input int max_cycles, input string tag);
        int k = 0;
        while (m_phase != ph && k < max_cycles) begin
            cycle();
            k++;
        end
        if (m_phase != ph) bound_fail(tag);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int n, guard;

        @(posedge clk);
        #1;
        model_step();
        check_all_zero("reset");
        rst_n = 1'b1;

        // A writes a full frame 0..63, value = addr, frame_done 20 cycles after
        clear_counters();
        a_req = 1'b1; n = 0; guard = 0;
        while (n < 64 && guard < 300) begin
            a_addr = 6'(n); a_value = 24'(n); a_last = (n == 63);
            cycle();
            if (m_acc) n++;
            guard++;
        end
        if (n < 64) bound_fail("full_frame_writes");
        a_req = 1'b0; a_last = 1'b0;
        repeat (20) cycle();
        frame_done = 1'b1; cycle(); frame_done = 1'b0;
        repeat (6) cycle();
        check("full_frame_wen_count", 32'(c_wr), 32'd64);
        check("full_frame_sends", 32'(c_send), 32'd1);
        check("full_frame_max_wif", 32'(c_max_cnt), 32'd64);
        check("full_frame_owner_clear", 32'(owner), 32'd0);

        // both requesters from reset: A first, B next while A keeps asking
        pulse_reset();
        clear_counters();
        a_req = 1'b1; b_req = 1'b1;
        repeat (100) begin
            a_addr = 6'($urandom); a_value = 24'($urandom); a_last = ($urandom_range(0, 3) == 0);
            b_addr = 6'($urandom); b_value = 24'($urandom); b_last = ($urandom_range(0, 3) == 0);
            frame_done = ($urandom_range(0, 4) == 0);
            cycle();
        end
        a_req = 1'b0; b_req = 1'b0; a_last = 1'b0; b_last = 1'b0; frame_done = 1'b0;
        if (seq.size() < 2) bound_fail("contention_two_frames");
        else begin
            check("contention_first_owner", 32'(seq[0]), 32'd1);
            check("contention_second_owner", 32'(seq[1]), 32'd2);
        end
        check("contention_b_gnt_under_a", 32'(c_bgnt_under_a), 32'd0);

        // one A frame to hand priority to B, then B writes 3 and stalls
        pulse_reset();
        a_req = 1'b1; a_last = 1'b1;
        run_until(P_WAIT, 10, "prio_frame_commit");
        a_req = 1'b0; a_last = 1'b0;
        frame_done = 1'b1; cycle(); frame_done = 1'b0;
        run_until(P_FREE, 10, "prio_frame_settle");
        b_req = 1'b1; n = 0; guard = 0;
        while (n < 3 && guard < 20) begin
            b_addr = 6'($urandom); b_value = 24'($urandom);
            cycle();
            if (m_acc) n++;
            guard++;
        end
        if (n < 3) bound_fail("timeout_b_writes");
        b_req = 1'b0;
        clear_counters();
        repeat (TMO + 4) cycle();
        check("timeout_abort_count", 32'(c_abort), 32'd1);
        check("timeout_send_count", 32'(c_send), 32'd0);
        check("timeout_owner_clear", 32'(owner), 32'd0);
        a_req = 1'b1; b_req = 1'b1;
        cycle();
        check("timeout_next_owner", 32'(owner), 32'd1);

        // frame_done during OWN is ignored; writes held off through send/settle
        a_req = 1'b0; b_req = 1'b0;
        pulse_reset();
        clear_counters();
        a_req = 1'b1; n = 0; guard = 0;
        while (n < 6 && guard < 40) begin
            a_addr = 6'($urandom); a_value = 24'($urandom); a_last = (n == 5);
            frame_done = (n == 2) && (m_phase == P_WRITING);
            cycle();
            if (m_acc) n++;
            guard++;
        end
        if (n < 6) bound_fail("own_done_writes");
        a_last = 1'b0; frame_done = 1'b0;
        repeat (3) cycle();
        frame_done = 1'b1; cycle(); frame_done = 1'b0;
        repeat (6) cycle();
        check("own_done_sends", 32'(c_send), 32'd1);
        check("own_done_wen_blocked", 32'(c_wr_blocked), 32'd0);

        // reset while waiting to commit discards the frame
        a_last = 1'b1;
        run_until(P_WAIT, 20, "reset_commit_reach");
        a_req = 1'b0; a_last = 1'b0;
        pulse_reset();
        check_all_zero("reset_in_commit");
        clear_counters();
        frame_done = 1'b1; cycle(); frame_done = 1'b0;
        repeat (4) cycle();
        check("reset_in_commit_sends", 32'(c_send), 32'd0);

        // 130 writes with repeated addresses; frame_done on COMMIT entry
        clear_counters();
        a_req = 1'b1; n = 0; guard = 0;
        while (n < 130 && guard < 400) begin
            a_addr = 6'(n % 64); a_value = 24'($urandom); a_last = (n == 129);
            cycle();
            if (m_acc) n++;
            guard++;
        end
        if (n < 130) bound_fail("saturate_writes");
        a_req = 1'b0; a_last = 1'b0;
        frame_done = 1'b1; cycle(); frame_done = 1'b0;
        repeat (6) cycle();
        check("saturate_wen_count", 32'(c_wr), 32'd130);
        check("saturate_max_wif", 32'(c_max_cnt), 32'd127);
        check("saturate_sends", 32'(c_send), 32'd1);

        // random soak
        repeat (3000) begin
            rst_n = ($urandom_range(0, 499) != 0);
            a_req = 1'($urandom_range(0, 1)); b_req = 1'($urandom_range(0, 1));
            a_addr = 6'($urandom); a_value = 24'($urandom); a_last = ($urandom_range(0, 7) == 0);
            b_addr = 6'($urandom); b_value = 24'($urandom); b_last = ($urandom_range(0, 7) == 0);
            frame_done = ($urandom_range(0, 5) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_write_scheduler.md
Name: frame_write_scheduler

Overview:
- Controller in front of `pixel_column_mux`.
- Arbitrates pixel writes from two requesters: A = host loader, B = pattern generator.
- Grants frame ownership to one requester at a time, forwards its writes to the mux write port, then commits the frame by pulsing `send_frame` aligned to the mux `frame_done` boundary.
- Guarantees frames from A and B never interleave, and no writes hit the mux during its buffer swap.

Parameters:
- BITS_PER_PIXEL, 24, width of a pixel value.
- TIMEOUT, 1024, idle cycles an owner may stall, without a write, before its ownership is revoked.
- SETTLE_CYCLES, 2, write-blocked cycles after a `send_frame` pulse.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- a_req  in  1  requester A has a valid write
- a_addr  in  6  requester A pixel address
- a_value  in  BITS_PER_PIXEL  requester A pixel value
- a_last  in  1  qualifies the A write as the final write of its frame
- a_gnt  out  1  A write accepted this cycle
- b_req, b_addr, b_value, b_last, b_gnt  same as A, for requester B
- frame_done  in  1  one-cycle pulse from the mux after column 7 is shown
- write_en  out  1  to mux
- pixel_addr  out  6  to mux
- pixel_value  out  BITS_PER_PIXEL  to mux
- send_frame  out  1  to mux, one-cycle pulse
- owner  out  2  00 none, 01 A, 10 B
- writes_in_frame  out  7  accepted writes in the current frame, saturates at 127
- abort  out  1  one-cycle pulse when ownership is revoked by timeout

Behaviour:
- Reset: clk/rst_n are one clock with synchronous active-low reset, sampled on posedge clk. Every output and register is 0 and the state is IDLE; round-robin priority favours A first. Reset mid-frame discards ownership without a commit.
- States: IDLE, OWN, COMMIT, SEND, SETTLE.
- IDLE:
  - If any req is high, pick the winner. If both are high, the winner is the requester not granted last frame.
  - Set owner and go to OWN. No write is accepted in this cycle.
- OWN:
  - x_gnt = x_req while owner == x. It is combinational and is never high for the non-owner.
  - On accept (req & gnt), the next cycle drives write_en = 1 with the registered addr/value (1-cycle latency). Otherwise write_en = 0.
  - Each accept increments writes_in_frame, saturating at 127.
  - Accept with last set: go to COMMIT; no further grants.
  - Timeout counter: resets on each accept and increments on idle OWN cycles. When it reaches TIMEOUT-1:
    - pulse abort;
    - clear owner and writes_in_frame;
    - go to IDLE;
    - flip round-robin priority;
    - do not pulse send_frame. Already-written pixels remain in the inactive grid.
- COMMIT:
  - Wait for frame_done.
  - frame_done in the same cycle as the COMMIT entry counts.
  - frame_done arriving during OWN is ignored.
- SEND:
  - Entered the cycle after frame_done.
  - send_frame = 1 for exactly this one cycle.
  - Update the round-robin pointer to the non-owner.
- SETTLE:
  - Block all grants for SETTLE_CYCLES cycles, counted via a down-counter.
  - Then clear owner and writes_in_frame, and go to IDLE.
- Invariants:
  - a_gnt and b_gnt are never both high.
  - write_en is never high during SEND or SETTLE.
  - send_frame is never high outside SEND.
- Duplicate addresses are forwarded unchanged; the last write wins in the grid.
- Unused inputs (addr/value without req) are ignored.

Decomposition:
- Shared package holds:
  - OWNER_NONE/OWNER_A/OWNER_B encodings;
  - state encodings;
  - BITS_PER_PIXEL and PIXELS_PER_FRAME = 64 constants (also used by the mux and grids).
- One natural sub-module: `rr_arbiter2`, a 2-way round-robin picker with a priority register and an update strobe.
- Timeout and settle counters stay inline.

Test Plan:
- A writes addr 0..63 with value = addr, last on 63, frame_done 20 cycles later:
  - write_en is seen 64 times, each 1 cycle after its grant;
  - send_frame pulses exactly 1 cycle after frame_done;
  - owner returns to 00 after 2 settle cycles;
  - writes_in_frame == 64 before the clear.
- a_req and b_req both high from reset:
  - A owns first and b_gnt stays 0 for A's whole frame;
  - after A commits, B owns the next frame while A is still requesting.
- B is granted, makes 3 writes, then idles for TIMEOUT cycles:
  - abort pulses once; no send_frame;
  - owner = 00; the next grant goes to A.
- frame_done pulses while A is mid-frame (OWN) and again after last:
  - only the post-last pulse produces send_frame;
  - no write_en in SEND/SETTLE even though a_req is held high.
- rst_n low for 1 cycle during COMMIT:
  - the next cycle has all outputs 0, state IDLE, and no send_frame on the following frame_done.
- 130 writes with duplicate addresses before last:
  - writes_in_frame saturates at 127;
  - all 130 writes are forwarded to the mux.
